seed_run_controller: RTL and testbench



---
 rtl/seed_run_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_seed_run_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_run_controller.sv
// ---------------------------------------------------------------------------
// seed_run_controller
//
// Purpose:
//   Sequencer for one gSROr datapath. For every seed in a synchronous seed
//   ROM it runs the datapath reset / inhibitor-load / start protocol. It then
//   waits for the run to finish and offers the final network state on a
//   valid/ready result port. A batch starts on `go` and ends with a one-cycle
//   `done`, unless `abort` cuts it short.
//
// Build option:
//   SEED_RUN_EARLY_EXIT_EN - when defined, RUN also ends as soon as the
//   datapath reports steady state. When undefined, RUN ends only on the
//   iteration limit.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-low reset
//   go, abort            batch start pulse (IDLE only) / abort level
//   inhibitor_sel        node to inhibit, latched when go is accepted
//   busy, done           not-IDLE flag / end-of-batch pulse
//   seed_addr/rdata      seed ROM port (1-cycle read latency)
//   dp_*                 datapath control outputs and status inputs
//   res_*                result payload with valid/ready handshake
//   ss_count             results with steady state in current/last batch
//
// All outputs are registered. Each one is decoded from the next state, so
// the registered value always matches the state the FSM is in.
// ---------------------------------------------------------------------------
module seed_run_controller #(
    parameter int RULES            = 32,
    parameter int LOG_RULES        = 5,
    parameter int LOG_ITER         = 10,
    parameter int ITERATION_NUMBER = 1000,
    parameter int NUM_SEEDS        = 16,
    parameter int LOG_SEEDS        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [LOG_RULES-1:0] inhibitor_sel,
    output logic                 busy,
    output logic                 done,
    output logic [LOG_SEEDS-1:0] seed_addr,
    input  logic [63:0]          seed_rdata,
    output logic                 dp_rst,
    output logic                 dp_start,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic [63:0]          dp_seed,
    input  logic [LOG_ITER-1:0]  dp_iteration_number,
    input  logic                 dp_steady_state,
    input  logic [RULES-1:0]     dp_network_state,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [LOG_SEEDS-1:0] res_seed_idx,
    output logic [RULES-1:0]     res_state,
    output logic                 res_steady,
    output logic [LOG_ITER-1:0]  res_iter,
    output logic [LOG_SEEDS:0]   ss_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_RST0, S_RST1, S_REL, S_INHIB,
        S_GAP0, S_START, S_GAP1, S_RUN, S_REPORT, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LOG_SEEDS-1:0] idx_q, idx_d;
    logic [LOG_SEEDS-1:0] seed_addr_q, seed_addr_d;
    logic [LOG_RULES-1:0] sel_q, sel_d;
    logic [63:0]          seed_q, seed_d;
    logic [LOG_SEEDS-1:0] res_idx_q, res_idx_d;
    logic [RULES-1:0]     res_state_q, res_state_d;
    logic                 res_steady_q, res_steady_d;
    logic [LOG_ITER-1:0]  res_iter_q, res_iter_d;
    logic [LOG_SEEDS:0]   ss_q, ss_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dp_rst_q, dp_rst_d;
    logic                 start_q, start_d;
    logic                 ld_q, ld_d;
    logic                 valid_q, valid_d;

    logic iter_limit;
    logic run_exit;
    logic last_seed;

    assign iter_limit = (dp_iteration_number >= LOG_ITER'(ITERATION_NUMBER));
    assign last_seed  = (idx_q == LOG_SEEDS'(NUM_SEEDS - 1));

`ifdef SEED_RUN_EARLY_EXIT_EN
    assign run_exit = iter_limit || dp_steady_state;
`else
    assign run_exit = iter_limit;
`endif

    // Next-state logic plus the datapath-facing registers.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        seed_d       = seed_q;
        res_idx_d    = res_idx_q;
        res_state_d  = res_state_q;
        res_steady_d = res_steady_q;
        res_iter_d   = res_iter_q;
        ss_d         = ss_q;

        if (abort && (state_q != S_IDLE)) begin
            // Abort wins over everything, including a pending result transfer.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go && !abort) begin
                        sel_d   = inhibitor_sel;
                        idx_d   = '0;
                        ss_d    = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    // ROM data for the address issued in FETCH is valid now.
                    seed_d  = seed_rdata;
                    state_d = S_RST0;
                end
                S_RST0:  state_d = S_RST1;
                S_RST1:  state_d = S_REL;
                S_REL:   state_d = S_INHIB;
                S_INHIB: state_d = S_GAP0;
                S_GAP0:  state_d = S_START;
                S_START: state_d = S_GAP1;
                S_GAP1:  state_d = S_RUN;
                S_RUN: begin
                    if (run_exit) begin
                        res_idx_d    = idx_q;
                        res_state_d  = dp_network_state;
                        res_steady_d = dp_steady_state;
                        res_iter_d   = dp_iteration_number;
                        state_d      = S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        ss_d = ss_q + {{LOG_SEEDS{1'b0}}, res_steady_q};
                        if (last_seed) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        start_d     = (state_d == S_START);
        ld_d        = (state_d == S_INHIB);
        valid_d     = (state_d == S_REPORT);
        dp_rst_d    = !(state_d inside {S_IDLE, S_FETCH, S_LOAD, S_RST0, S_RST1});
        seed_addr_d = (state_d == S_FETCH) ? idx_d : seed_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            seed_addr_q  <= '0;
            sel_q        <= '0;
            seed_q       <= '0;
            res_idx_q    <= '0;
            res_state_q  <= '0;
            res_steady_q <= 1'b0;
            res_iter_q   <= '0;
            ss_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dp_rst_q     <= 1'b0;
            start_q      <= 1'b0;
            ld_q         <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            seed_addr_q  <= seed_addr_d;
            sel_q        <= sel_d;
            seed_q       <= seed_d;
            res_idx_q    <= res_idx_d;
            res_state_q  <= res_state_d;
            res_steady_q <= res_steady_d;
            res_iter_q   <= res_iter_d;
            ss_q         <= ss_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dp_rst_q     <= dp_rst_d;
            start_q      <= start_d;
            ld_q         <= ld_d;
            valid_q      <= valid_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign seed_addr        = seed_addr_q;
    assign dp_rst           = dp_rst_q;
    assign dp_start         = start_q;
    assign dp_ld_inhibitor  = ld_q;
    assign dp_sel_inhibitor = sel_q;
    assign dp_seed          = seed_q;
    assign res_valid        = valid_q;
    assign res_seed_idx     = res_idx_q;
    assign res_state        = res_state_q;
    assign res_steady       = res_steady_q;
    assign res_iter         = res_iter_q;
    assign ss_count         = ss_q;

endmodule

// File: tb/tb_seed_run_controller.sv
// ---------------------------------------------------------------------------
// tb_seed_run_controller
//
// Drives batches of 4 seeds through the controller. A simple datapath stand-in
// counts iterations after dp_start and raises steady state at a per-seed
// iteration. A reference model predicts each seed's result from those rules.
// ---------------------------------------------------------------------------
module tb_seed_run_controller;
    localparam int RULES     = 32;
    localparam int LOG_RULES = 5;
    localparam int LOG_ITER  = 10;
    localparam int ITER_N    = 1000;
    localparam int NS        = 4;
    localparam int LOG_SEEDS = 2;
    localparam logic [31:0] MIX = 32'h9E3779B1;
`ifdef SEED_RUN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 go = 1'b0, abort = 1'b0;
    logic [LOG_RULES-1:0] inhibitor_sel = '0;
    logic                 busy, done;
    logic [LOG_SEEDS-1:0] seed_addr;
    logic [63:0]          seed_rdata = '0;
    logic                 dp_rst, dp_start, dp_ld_inhibitor;
    logic [LOG_RULES-1:0] dp_sel_inhibitor;
    logic [63:0]          dp_seed;
    logic [LOG_ITER-1:0]  dp_iter;
    logic                 dp_steady;
    logic [RULES-1:0]     dp_net;
    logic                 res_valid, res_ready = 1'b1;
    logic [LOG_SEEDS-1:0] res_seed_idx;
    logic [RULES-1:0]     res_state;
    logic                 res_steady;
    logic [LOG_ITER-1:0]  res_iter;
    logic [LOG_SEEDS:0]   ss_count;

    seed_run_controller #(
        .RULES(RULES), .LOG_RULES(LOG_RULES), .LOG_ITER(LOG_ITER),
        .ITERATION_NUMBER(ITER_N), .NUM_SEEDS(NS), .LOG_SEEDS(LOG_SEEDS)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .inhibitor_sel(inhibitor_sel),
        .busy(busy), .done(done), .seed_addr(seed_addr), .seed_rdata(seed_rdata),
        .dp_rst(dp_rst), .dp_start(dp_start), .dp_ld_inhibitor(dp_ld_inhibitor),
        .dp_sel_inhibitor(dp_sel_inhibitor), .dp_seed(dp_seed),
        .dp_iteration_number(dp_iter), .dp_steady_state(dp_steady),
        .dp_network_state(dp_net), .res_valid(res_valid), .res_ready(res_ready),
        .res_seed_idx(res_seed_idx), .res_state(res_state), .res_steady(res_steady),
        .res_iter(res_iter), .ss_count(ss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: seed ROM and datapath stand-in ----------
    logic [63:0] rom [NS];
    int          steady_at [NS];

    always @(posedge clk) seed_rdata <= rom[seed_addr];

    function automatic int steady_of(input logic [63:0] s);
        for (int i = 0; i < NS; i++)
            if (rom[i] == s) return steady_at[i];
        return 100000;
    endfunction

    logic dp_run;
    int   cur_sa;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_run <= 1'b0; dp_iter <= '0; cur_sa <= 100000;
        end else if (!dp_rst) begin
            dp_run <= 1'b0; dp_iter <= '0;
        end else if (dp_start) begin
            dp_run <= 1'b1; dp_iter <= '0; cur_sa <= steady_of(dp_seed);
        end else if (dp_run && dp_iter != '1) begin
            dp_iter <= dp_iter + 1'b1;
        end
    end
    assign dp_steady = dp_run && (int'(dp_iter) >= cur_sa);
    assign dp_net    = dp_seed[31:0] ^ dp_seed[63:32] ^ (32'(dp_iter) * MIX);

    // ---------------- reference model ------------------------------------
    typedef struct {
        int          idx;
        logic [31:0] st;
        bit          steady;
        int          iter;
    } res_t;

    res_t                 exp_q[$];
    int                   model_ss = 0;
    logic [LOG_RULES-1:0] model_sel = '0;
    bit                   chk_en = 1'b0;
    int                   dones = 0, starts = 0;
    int                   got_iter [NS];
    bit                   got_steady [NS];

    // Result for seed i: run ends at the iteration limit, or earlier at the
    // steady iteration when early exit is built in.
    function automatic res_t expect_of(input int i);
        res_t r;
        int   sa;
        sa       = steady_at[i];
        r.idx    = i;
        r.steady = (sa <= ITER_N);
        r.iter   = (EARLY && sa <= ITER_N) ? sa : ITER_N;
        r.st     = rom[i][31:0] ^ rom[i][63:32] ^ (32'(r.iter) * MIX);
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------------------------
    always @(negedge clk) begin
        if (rst && chk_en) begin
            chk("ss_count", 64'(ss_count), 64'(model_ss));
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got idx %0d expected no result", res_seed_idx);
                end else begin
                    chk("res_seed_idx", 64'(res_seed_idx), 64'(exp_q[0].idx));
                    chk("res_state",    64'(res_state),    64'(exp_q[0].st));
                    chk("res_steady",   64'(res_steady),   64'(exp_q[0].steady));
                    chk("res_iter",     64'(res_iter),     64'(exp_q[0].iter));
                    chk("dp_rst_in_report", 64'(dp_rst), 64'd1);
                    chk("no_start_in_report", 64'(dp_start), 64'd0);
                    if (res_ready && !abort) begin
                        model_ss += exp_q[0].steady ? 1 : 0;
                        got_iter[res_seed_idx]   = int'(res_iter);
                        got_steady[res_seed_idx] = res_steady;
                        $display("xfer idx=%0d iter=%0d steady=%0b state=%08h",
                                 res_seed_idx, res_iter, res_steady, res_state);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (dp_start) begin
                starts++;
                if (exp_q.size() != 0)
                    chk("dp_seed_at_start", dp_seed, rom[exp_q[0].idx]);
            end
            if (dp_ld_inhibitor)
                chk("dp_sel_inhibitor", 64'(dp_sel_inhibitor), 64'(model_sel));
            if (done) dones++;
        end
    end

    // ---------------- result-ready driver --------------------------------
    int rmode = 0;       // 0: always ready, 1: random, 2: hold off 20 cycles
    int vcnt = 0;
    bit seen_stall = 1'b0;
    always @(posedge clk) begin
        #1;
        vcnt = res_valid ? vcnt + 1 : 0;
        if (vcnt >= 20 && res_valid) seen_stall = 1'b1;
        case (rmode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = (vcnt > 20);
        endcase
    end

    // ---------------- stimulus tasks -------------------------------------
    task automatic randomize_batch();
        for (int i = 0; i < NS; i++) begin
            rom[i]       = {$urandom, $urandom};
            steady_at[i] = $urandom_range(2, 1100);
        end
    endtask

    task automatic start_batch(input bit proto);
        logic [LOG_RULES-1:0] s;
        s = LOG_RULES'($urandom);
        @(posedge clk); #1;
        go = 1'b1; inhibitor_sel = s;
        @(posedge clk); #1;
        go = 1'b0;
        model_ss = 0; model_sel = s;
        exp_q.delete();
        for (int i = 0; i < NS; i++) exp_q.push_back(expect_of(i));
        $display("batch start sel=%0d proto=%0b", s, proto);
        if (proto) begin
            for (int k = 1; k <= 9; k++) begin
                if (k > 1) @(posedge clk);
                @(negedge clk);
                chk($sformatf("proto_dp_rst_c%0d", k), 64'(dp_rst), 64'(k >= 5));
                chk($sformatf("proto_ld_c%0d", k),     64'(dp_ld_inhibitor), 64'(k == 6));
                chk($sformatf("proto_start_c%0d", k),  64'(dp_start), 64'(k == 8));
                chk($sformatf("proto_busy_c%0d", k),   64'(busy), 64'd1);
            end
        end
    endtask

    task automatic finish_batch(input bit poke);
        int d0, cyc;
        d0  = dones;
        cyc = 0;
        if (poke) begin
            repeat (100) @(posedge clk);
            #1; go = 1'b1; inhibitor_sel = ~model_sel;
            @(posedge clk); #1; go = 1'b0;
        end
        while (dones == d0 && cyc < 8000) begin
            @(posedge clk); cyc++;
        end
        chk("done_within_budget", 64'(cyc < 8000), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        chk("done_pulses", 64'(dones - d0), 64'd1);
        chk("results_drained", 64'(exp_q.size()), 64'd0);
        $display("batch end ss_count=%0d", ss_count);
    endtask

    // ---------------- main sequence --------------------------------------
    initial begin
        randomize_batch();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);                 chk("rst_done", 64'(done), 0);
        chk("rst_dp_start", 64'(dp_start), 0);         chk("rst_dp_ld", 64'(dp_ld_inhibitor), 0);
        chk("rst_dp_rst", 64'(dp_rst), 0);             chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_steady", 64'(res_steady), 0);     chk("rst_seed_addr", 64'(seed_addr), 0);
        chk("rst_dp_seed", dp_seed, 0);                chk("rst_dp_sel", 64'(dp_sel_inhibitor), 0);
        chk("rst_res_idx", 64'(res_seed_idx), 0);      chk("rst_res_state", 64'(res_state), 0);
        chk("rst_res_iter", 64'(res_iter), 0);         chk("rst_ss_count", 64'(ss_count), 0);
        @(posedge clk); #1; rst = 1'b1; chk_en = 1'b1;

        // Batch 1: always ready, protocol timing, pinned seeds 0 and 1.
        randomize_batch();
        steady_at[0] = 37; steady_at[1] = 2000;
        start_batch(1'b1);
        finish_batch(1'b0);
        chk("seed0_iter_literal", 64'(got_iter[0]), EARLY ? 64'd37 : 64'd1000);
        chk("seed0_steady_literal", 64'(got_steady[0]), 64'd1);
        chk("seed1_iter_literal", 64'(got_iter[1]), 64'd1000);
        chk("seed1_steady_literal", 64'(got_steady[1]), 64'd0);

        // Batch 2: random ready, plus a go pulse during RUN that must be ignored.
        rmode = 1; randomize_batch();
        start_batch(1'b0);
        finish_batch(1'b1);

        // Batch 3: 20-cycle backpressure on every result.
        rmode = 2; seen_stall = 1'b0; randomize_batch();
        start_batch(1'b0);
        finish_batch(1'b0);
        chk("stall_seen", 64'(seen_stall), 64'd1);

        // Abort during RUN of seed 2.
        rmode = 0; randomize_batch();
        begin
            int s0, cyc, d0;
            s0 = starts; cyc = 0;
            start_batch(1'b0);
            while (starts < s0 + 3 && cyc < 8000) begin @(posedge clk); cyc++; end
            chk("abort_reached_seed2", 64'(cyc < 8000), 64'd1);
            repeat (50) @(posedge clk);
            d0 = dones;
            #1; abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_dp_rst", 64'(dp_rst), 64'd0);
            chk("abort_res_valid", 64'(res_valid), 64'd0);
            repeat (10) @(posedge clk);
            chk("abort_no_done", 64'(dones - d0), 64'd0);
            exp_q.delete();
            $display("abort issued during seed 2");
        end

        // Restart after abort: seed 0 first and ss_count cleared.
        randomize_batch();
        start_batch(1'b0);
        finish_batch(1'b0);

        // go together with abort in IDLE: nothing happens.
        @(posedge clk); #1; go = 1'b1; abort = 1'b1;
        @(posedge clk); #1; go = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("go_abort_idle_busy", 64'(busy), 64'd0);
        end
        $display("go+abort in IDLE ignored");

        // Asynchronous reset in the middle of a run.
        randomize_batch();
        start_batch(1'b0);
        repeat (200) @(posedge clk);
        #1; chk_en = 1'b0; rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_dp_rst", 64'(dp_rst), 64'd0);
        chk("midrst_dp_seed", dp_seed, 64'd0);
        chk("midrst_ss_count", 64'(ss_count), 64'd0);
        model_ss = 0; exp_q.delete();
        @(posedge clk); #1; rst = 1'b1; chk_en = 1'b1;
        $display("mid-run reset applied");

        // Final batch with random ready.
        rmode = 1; randomize_batch();
        start_batch(1'b0);
        finish_batch(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
